// File: rtl/cut_bist_controller.sv
// BIST sequencer: LFSR patterns drive the CUT, each held SETTLE cycles, responses folded into a MISR.
// Start to done takes 2 + num_pat*(SETTLE+1) cycles; start is ignored while busy, abort returns to IDLE.
module cut_bist_controller #(
    parameter int              N_IN   = 32,
    parameter int              N_OUT  = 32,
    parameter int              PAT_W  = 16,
    parameter int              SETTLE = 2,
    parameter logic [N_IN-1:0]  LTAPS  = 32'h80200003,
    parameter logic [N_OUT-1:0] MTAPS  = 32'h80200003
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [PAT_W-1:0]  num_pat,
    input  logic [N_IN-1:0]   seed,
    input  logic [N_OUT-1:0]  golden,
    output logic [N_IN-1:0]   cut_in,
    input  logic [N_OUT-1:0]  cut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_OUT-1:0]  signature,
    output logic [PAT_W-1:0]  pat_cnt
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_APPLY,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [N_IN-1:0]   lfsr;
    logic [N_OUT-1:0]  misr;
    logic [PAT_W-1:0]  cnt, num_q;
    logic [PAT_W-1:0]  cnt_inc;
    logic [SW-1:0]     settle;

    assign cnt_inc = cnt + PAT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start && !abort) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (abort)                 state_nxt = S_IDLE;
                else if (num_pat == '0)    state_nxt = S_DONE;
                else                       state_nxt = S_APPLY;
            end
            S_APPLY: begin
                if (abort)                 state_nxt = S_IDLE;
                else if (settle == '0)     state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                // abort outranks the final capture's move to DONE
                if (abort)                 state_nxt = S_IDLE;
                else if (cnt_inc == num_q) state_nxt = S_DONE;
                else                       state_nxt = S_APPLY;
            end
            S_DONE: begin
                if (start) state_nxt = abort ? S_IDLE : S_LOAD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // An aborted cycle leaves the datapath untouched so partial results stay visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr   <= '0;
            misr   <= '0;
            cnt    <= '0;
            num_q  <= '0;
            settle <= '0;
        end else if (!abort) begin
            case (state)
                S_LOAD: begin
                    lfsr   <= (seed == '0) ? N_IN'(1) : seed;
                    misr   <= '0;
                    cnt    <= '0;
                    num_q  <= num_pat;
                    settle <= SW'(SETTLE - 1);
                end
                S_APPLY: begin
                    if (settle != '0) settle <= settle - SW'(1);
                end
                S_CAPTURE: begin
                    misr   <= {misr[N_OUT-2:0], ^(misr & MTAPS)} ^ cut_out;
                    lfsr   <= {lfsr[N_IN-2:0], ^(lfsr & LTAPS)};
                    cnt    <= cnt_inc;
                    settle <= SW'(SETTLE - 1);
                end
                default: ;
            endcase
        end
    end

    assign cut_in    = lfsr;
    assign signature = misr;
    assign pat_cnt   = cnt;
    assign busy      = (state == S_LOAD) || (state == S_APPLY) || (state == S_CAPTURE);
    assign done      = (state == S_DONE);
    assign pass      = done && (misr == golden);

endmodule
